sd_arbiter: RTL and testbench
=============================

SD_ARBITER -- requirements
Module: sd_arbiter

Interface
REQ-001 Parameter LATENCY, default 2: cycles from mem_addr driven to mem_out valid on a read, legal range 1..7.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 r0_req / r1_req  input  1  request from requester 0 (CPU) / 1 (DMA), held until the matching ack.
REQ-005 r0_we / r1_we  input  1  1 = write, 0 = read; sampled at grant.
REQ-006 r0_addr / r1_addr  input  4  half-word address; sampled at grant.
REQ-007 r0_wdata / r1_wdata  input  16  write data; sampled at grant.
REQ-008 r0_ack / r1_ack  output  1  one-cycle completion pulse.
REQ-009 r0_rdata / r1_rdata  output  16  read data, valid with ack, held until the next read ack to that requester.
REQ-010 mem_addr  output  4  address to the SD mapper.
REQ-011 mem_we  output  1  write strobe to the SD mapper.
REQ-012 mem_in  output  16  write data to the SD mapper.
REQ-013 mem_out  input  16  read data from the SD mapper.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 grant  output  1  id of the requester owning the current or last transaction.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, ACK.
- IDLE->ISSUE when any req is high.
- ISSUE->ACK on a write.
- ISSUE->WAIT on a read.
- WAIT->ACK when the latency counter reaches 0.
- ACK->IDLE unconditionally.
REQ-017 Arbitration in IDLE SHALL be round-robin: a single req wins; on simultaneous req, the requester not granted last wins; grant SHALL update on IDLE->ISSUE.
REQ-018 we/addr/wdata of the winner SHALL be captured on IDLE->ISSUE and drive mem_addr/mem_in from ISSUE through ACK.
REQ-019 mem_we SHALL be high exactly one cycle (ISSUE) for a write and low at all other times.
REQ-020 Read timing: the WAIT counter SHALL load LATENCY-1 on ISSUE->WAIT; mem_out SHALL be captured into the granted rdata on WAIT->ACK.
REQ-021 Latency from the cycle req is sampled high in IDLE: write ack at +2 cycles; read ack at +2+LATENCY cycles (LATENCY=2: +4).
REQ-022 Only the granted requester's ack SHALL pulse, for one cycle, in ACK; the non-granted rdata SHALL be unchanged.
REQ-023 A req dropped after grant SHALL NOT abort the transaction; ack still pulses.
REQ-024 A req still high in the cycle after ack SHALL be treated as a new request; under continuous dual requests, grants SHALL alternate 0,1,0,1.
REQ-025 Addresses 0..15 SHALL pass unmodified with no wrap or range check.

Reset
REQ-026 While reset is low, all of the following SHALL be 0, asynchronously: state=IDLE, acks, rdata, mem_addr, mem_in, mem_we, busy, grant, counter.
REQ-027 The last-grant pointer SHALL reset to 1 so requester 0 wins the first contention.
REQ-028 Reset asserted mid-transaction SHALL abort it with no ack issued; mem_we SHALL drop immediately.

Structure
REQ-029 ADDR_W=4, DATA_W=16 and the state encoding SHALL live in shared package sd_pkg.
REQ-030 One sub-module, sd_rr_pick (2-way round-robin select from req pair plus last-grant), SHALL be used; everything else stays in sd_arbiter.

Verification
REQ-031 Write: r0_req, we=1, addr=2, wdata=16'hfafa -> mem_we high one cycle with mem_addr=2, mem_in=16'hfafa; r0_ack at +2.
REQ-032 Read: r1_req, we=0, addr=1, mem_out=16'hcafe at LATENCY -> r1_ack at +4 with r1_rdata=16'hcafe; r0_rdata stays 0.
REQ-033 Contention: r0_req and r1_req high together for 4 transactions -> grant order 0,1,0,1; no overlapping acks.
REQ-034 Dropped req: r0_req high one cycle only (write, addr 3) -> transaction completes, r0_ack pulses once.
REQ-035 Reset mid-read: reset low during WAIT -> all outputs 0 at once, no ack; after release, a new r1 read completes normally.
REQ-036 LATENCY=1 build: read ack at +3 with correct data; addr=15 appears on mem_addr unchanged.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared widths, FSM state encoding and request record for the SD arbiter.
package sd_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    // Arbiter FSM encoding, kept as plain constants so older tools can read it.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    // One captured memory request as seen at grant time.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xact_t;

    // Bundle the loose request fields of one requester into a record.
    function automatic xact_t make_xact(input logic              we,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata);
        xact_t x;
        x.we    = we;
        x.addr  = addr;
        x.wdata = wdata;
        return x;
    endfunction

endpackage

// File: rtl/sd_rr_pick.sv
// Two-way round-robin selector: a lone request wins, a tie goes to the
// requester that was not served last.
module sd_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic pick
);

    assign valid = req0 | req1;

    // Tie-break against the previous winner, otherwise take whoever asks.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

endmodule

// File: rtl/sd_arbiter.sv
// Round-robin arbiter sharing one SD mapper port between a CPU (requester 0)
// and a DMA engine (requester 1). Writes take one issue cycle, reads wait
// LATENCY cycles for mem_out before completing.
module sd_arbiter
    import sd_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy,
    output logic              grant
);

    // The wait counter is loaded with LATENCY-1 so the last WAIT cycle is
    // exactly the one in which the mapper presents valid read data.
    localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

    logic [1:0]        state;
    logic [1:0]        next_state;
    xact_t             cur;
    logic              grant_q;
    logic              last_q;
    logic [2:0]        cnt;
    logic [DATA_W-1:0] r0_rdata_q;
    logic [DATA_W-1:0] r1_rdata_q;
    logic              pick_valid;
    logic              pick_id;
    logic              take;
    logic              read_done;

    sd_rr_pick u_pick (
        .req0  (r0_req),
        .req1  (r1_req),
        .last  (last_q),
        .valid (pick_valid),
        .pick  (pick_id)
    );

    assign take      = (state == ST_IDLE) && pick_valid;
    assign read_done = (state == ST_WAIT) && (cnt == 3'd0);

    // Next-state decode for the IDLE/ISSUE/WAIT/ACK transaction sequence.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (pick_valid) next_state = ST_ISSUE;
            ST_ISSUE: next_state = cur.we ? ST_ACK : ST_WAIT;
            ST_WAIT:  if (cnt == 3'd0) next_state = ST_ACK;
            ST_ACK:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch the winner's id and request fields when leaving IDLE. The
    // last-grant pointer starts at 1 so the CPU wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cur     <= '0;
        end else if (take) begin
            grant_q <= pick_id;
            last_q  <= pick_id;
            cur     <= pick_id ? make_xact(r1_we, r1_addr, r1_wdata)
                               : make_xact(r0_we, r0_addr, r0_wdata);
        end
    end

    // Read latency countdown, loaded when a read moves into WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 3'd0;
        end else if ((state == ST_ISSUE) && !cur.we) begin
            cnt <= CNT_LOAD;
        end else if ((state == ST_WAIT) && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
        end
    end

    // Capture read data for the owning requester only; the other keeps its value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
        end else if (read_done) begin
            if (grant_q) begin
                r1_rdata_q <= mem_out;
            end else begin
                r0_rdata_q <= mem_out;
            end
        end
    end

    assign mem_addr = cur.addr;
    assign mem_in   = cur.wdata;
    assign mem_we   = (state == ST_ISSUE) && cur.we;
    assign busy     = (state != ST_IDLE);
    assign grant    = grant_q;
    assign r0_ack   = (state == ST_ACK) && !grant_q;
    assign r1_ack   = (state == ST_ACK) && grant_q;
    assign r0_rdata = r0_rdata_q;
    assign r1_rdata = r1_rdata_q;

endmodule

// File: tb/tb_sd_arbiter.sv
// Self-checking bench for sd_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model, on LATENCY=2 and LATENCY=1 builds.
module tb_sd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [3:0]  r0_addr, r1_addr;
    logic [15:0] r0_wdata, r1_wdata;

    logic        d0_r0_ack, d0_r1_ack, d0_mem_we, d0_busy, d0_grant;
    logic [15:0] d0_r0_rdata, d0_r1_rdata, d0_mem_in, d0_mem_out;
    logic [3:0]  d0_mem_addr;
    logic        d1_r0_ack, d1_r1_ack, d1_mem_we, d1_busy, d1_grant;
    logic [15:0] d1_r0_rdata, d1_r1_rdata, d1_mem_in, d1_mem_out;
    logic [3:0]  d1_mem_addr;

    logic [15:0] map0 [16];
    logic [15:0] map1 [16];
    int          age0 = 0;
    int          age1 = 0;
    logic        ld = 1'b0;
    logic [3:0]  ld_addr = 4'd0;
    logic [15:0] ld_data = 16'd0;

    bit          sel_dut = 1'b0;
    logic        v_r0_ack, v_r1_ack, v_mem_we, v_busy, v_grant;
    logic [15:0] v_r0_rdata, v_r1_rdata, v_mem_in;
    logic [3:0]  v_mem_addr;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    sd_arbiter #(.LATENCY(2)) dut0 (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(d0_r0_ack), .r0_rdata(d0_r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(d0_r1_ack), .r1_rdata(d0_r1_rdata),
        .mem_addr(d0_mem_addr), .mem_we(d0_mem_we), .mem_in(d0_mem_in),
        .mem_out(d0_mem_out), .busy(d0_busy), .grant(d0_grant)
    );

    sd_arbiter #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(d1_r0_ack), .r0_rdata(d1_r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(d1_r1_ack), .r1_rdata(d1_r1_rdata),
        .mem_addr(d1_mem_addr), .mem_we(d1_mem_we), .mem_in(d1_mem_in),
        .mem_out(d1_mem_out), .busy(d1_busy), .grant(d1_grant)
    );

    // SD mapper stand-ins: storage plus a cycle counter since the port went
    // busy, so read data is valid only in the cycle exactly LATENCY after
    // mem_addr is first driven and garbage otherwise.
    always @(posedge clk) begin
        if (ld) begin
            map0[ld_addr] <= ld_data;
            map1[ld_addr] <= ld_data;
        end else begin
            if (d0_mem_we) map0[d0_mem_addr] <= d0_mem_in;
            if (d1_mem_we) map1[d1_mem_addr] <= d1_mem_in;
        end
        age0 <= d0_busy ? age0 + 1 : 0;
        age1 <= d1_busy ? age1 + 1 : 0;
    end

    assign d0_mem_out = (age0 == 2) ? map0[d0_mem_addr] : 16'h0bad;
    assign d1_mem_out = (age1 == 1) ? map1[d1_mem_addr] : 16'h0bad;

    assign v_r0_ack   = sel_dut ? d1_r0_ack   : d0_r0_ack;
    assign v_r1_ack   = sel_dut ? d1_r1_ack   : d0_r1_ack;
    assign v_r0_rdata = sel_dut ? d1_r0_rdata : d0_r0_rdata;
    assign v_r1_rdata = sel_dut ? d1_r1_rdata : d0_r1_rdata;
    assign v_mem_addr = sel_dut ? d1_mem_addr : d0_mem_addr;
    assign v_mem_in   = sel_dut ? d1_mem_in   : d0_mem_in;
    assign v_mem_we   = sel_dut ? d1_mem_we   : d0_mem_we;
    assign v_busy     = sel_dut ? d1_busy     : d0_busy;
    assign v_grant    = sel_dut ? d1_grant    : d0_grant;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic req, input logic we,
                           input logic [3:0] addr, input logic [15:0] wdata);
        if (i == 0) begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
        end else begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 4'd0, 16'd0);
        set_req(1, 1'b0, 1'b0, 4'd0, 16'd0);
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        ld = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld = 1'b0;
    endtask

    task automatic test_reset();
        logic [56:0] snap;
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 4'd0, 16'd0);
        set_req(1, 1'b0, 1'b0, 4'd0, 16'd0);
        step();
        for (int d = 0; d < 2; d++) begin
            sel_dut = (d == 1);
            #1;
            snap = {v_r0_ack, v_r1_ack, v_r0_rdata, v_r1_rdata, v_mem_addr,
                    v_mem_in, v_mem_we, v_busy, v_grant};
            n_total++;
            if (snap !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs dut%0d: got %h want 0", d, snap);
            end
        end
        sel_dut = 1'b0;
        step();
        reset = 1'b1;
        set_req(0, 1'b1, 1'b1, 4'd7, 16'haaaa);
        set_req(1, 1'b1, 1'b1, 4'd8, 16'hbbbb);
        step();
        n_total++;
        if (v_grant !== 1'b0 || v_mem_addr !== 4'd7) begin
            n_bad++;
            $display("FAIL reset_first_tie: got grant=%0d addr=%0d want grant=0 addr=7", v_grant, v_mem_addr);
        end
        do_reset();
    endtask

    task automatic test_write();
        sel_dut = 1'b0;
        set_req(0, 1'b1, 1'b1, 4'd2, 16'hfafa);
        step();
        n_total++;
        if ({v_mem_we, v_mem_addr, v_mem_in, v_busy, v_grant, v_r0_ack} !== {1'b1, 4'd2, 16'hfafa, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL write_issue: got we=%0d addr=%0d in=%h busy=%0d grant=%0d ack=%0d want 1 2 fafa 1 0 0",
                     v_mem_we, v_mem_addr, v_mem_in, v_busy, v_grant, v_r0_ack);
        end
        step();
        n_total++;
        if ({v_r0_ack, v_r1_ack, v_mem_we} !== 3'b100) begin
            n_bad++;
            $display("FAIL write_ack: got ack0=%0d ack1=%0d we=%0d want 1 0 0", v_r0_ack, v_r1_ack, v_mem_we);
        end
        set_req(0, 1'b0, 1'b0, 4'd0, 16'd0);
        step();
        n_total++;
        if ({v_r0_ack, v_busy} !== 2'b00 || map0[2] !== 16'hfafa) begin
            n_bad++;
            $display("FAIL write_done: got ack0=%0d busy=%0d mem[2]=%h want 0 0 fafa", v_r0_ack, v_busy, map0[2]);
        end
    endtask

    task automatic test_read();
        sel_dut = 1'b0;
        preload(4'd1, 16'hcafe);
        set_req(1, 1'b1, 1'b0, 4'd1, 16'd0);
        for (int c = 1; c <= 3; c++) begin
            step();
            n_total++;
            if (v_r1_ack !== 1'b0) begin
                n_bad++;
                $display("FAIL read_early_ack c%0d: got 1 want 0", c);
            end
        end
        step();
        n_total++;
        if ({v_r1_ack, v_r0_ack, v_r1_rdata, v_r0_rdata} !== {1'b1, 1'b0, 16'hcafe, 16'h0000}) begin
            n_bad++;
            $display("FAIL read_ack: got ack1=%0d ack0=%0d rd1=%h rd0=%h want 1 0 cafe 0000",
                     v_r1_ack, v_r0_ack, v_r1_rdata, v_r0_rdata);
        end
        set_req(1, 1'b0, 1'b0, 4'd0, 16'd0);
        step();
    endtask

    task automatic test_contention();
        int k = 0;
        sel_dut = 1'b0;
        set_req(0, 1'b1, 1'b1, 4'd4, 16'h1111);
        set_req(1, 1'b1, 1'b1, 4'd5, 16'h2222);
        for (int c = 1; c <= 30 && k < 4; c++) begin
            step();
            n_total++;
            if (v_r0_ack && v_r1_ack) begin
                n_bad++;
                $display("FAIL contention_overlap c%0d: got both acks want one", c);
            end else if (v_r0_ack || v_r1_ack) begin
                n_total++;
                if (v_r1_ack !== logic'(k % 2) || v_grant !== logic'(k % 2) || c != 2 + 3 * k) begin
                    n_bad++;
                    $display("FAIL contention_order #%0d: got ack1=%0d grant=%0d cycle=%0d want %0d %0d %0d",
                             k, v_r1_ack, v_grant, c, k % 2, k % 2, 2 + 3 * k);
                end
                k++;
            end
        end
        n_total++;
        if (k != 4) begin
            n_bad++;
            $display("FAIL contention_count: got %0d acks want 4", k);
        end
        set_req(0, 1'b0, 1'b0, 4'd0, 16'd0);
        set_req(1, 1'b0, 1'b0, 4'd0, 16'd0);
        step();
    endtask

    task automatic test_dropped_req();
        int acks = 0;
        sel_dut = 1'b0;
        set_req(0, 1'b1, 1'b1, 4'd3, 16'h3333);
        step();
        set_req(0, 1'b0, 1'b0, 4'd0, 16'd0);
        n_total++;
        if ({v_mem_we, v_mem_addr} !== {1'b1, 4'd3}) begin
            n_bad++;
            $display("FAIL drop_issue: got we=%0d addr=%0d want 1 3", v_mem_we, v_mem_addr);
        end
        for (int c = 2; c <= 6; c++) begin
            step();
            if (v_r0_ack) acks++;
            if (c == 2) begin
                n_total++;
                if (v_r0_ack !== 1'b1) begin
                    n_bad++;
                    $display("FAIL drop_ack_time: got %0d want 1", v_r0_ack);
                end
            end
        end
        n_total++;
        if (acks != 1 || v_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_ack_count: got acks=%0d busy=%0d want 1 0", acks, v_busy);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [56:0] snap;
        sel_dut = 1'b0;
        preload(4'd6, 16'hbeef);
        set_req(1, 1'b1, 1'b0, 4'd6, 16'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        snap = {v_r0_ack, v_r1_ack, v_r0_rdata, v_r1_rdata, v_mem_addr,
                v_mem_in, v_mem_we, v_busy, v_grant};
        n_total++;
        if (snap !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h want 0", snap);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            n_total++;
            if ({v_r1_ack, v_busy} !== 2'b00) begin
                n_bad++;
                $display("FAIL midreset_held: got ack1=%0d busy=%0d want 0 0", v_r1_ack, v_busy);
            end
        end
        reset = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_total++;
            if (v_r1_ack !== logic'(c == 4)) begin
                n_bad++;
                $display("FAIL midreset_reread c%0d: got ack1=%0d want %0d", c, v_r1_ack, c == 4);
            end
        end
        n_total++;
        if ({v_r1_rdata, v_r0_rdata} !== {16'hbeef, 16'h0000}) begin
            n_bad++;
            $display("FAIL midreset_data: got rd1=%h rd0=%h want beef 0000", v_r1_rdata, v_r0_rdata);
        end
        set_req(1, 1'b0, 1'b0, 4'd0, 16'd0);
        step();
    endtask

    task automatic test_latency1();
        do_reset();
        sel_dut = 1'b1;
        preload(4'd15, 16'h1234);
        set_req(0, 1'b1, 1'b0, 4'd15, 16'd0);
        step();
        n_total++;
        if ({v_mem_addr, v_mem_we, v_busy} !== {4'd15, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL lat1_issue: got addr=%0d we=%0d busy=%0d want 15 0 1", v_mem_addr, v_mem_we, v_busy);
        end
        step();
        n_total++;
        if (v_r0_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL lat1_early: got ack0=1 want 0");
        end
        step();
        n_total++;
        if ({v_r0_ack, v_r0_rdata} !== {1'b1, 16'h1234}) begin
            n_bad++;
            $display("FAIL lat1_ack: got ack0=%0d rd0=%h want 1 1234", v_r0_ack, v_r0_rdata);
        end
        set_req(0, 1'b0, 1'b0, 4'd0, 16'd0);
        step();
        sel_dut = 1'b0;
    endtask

    // Randomized traffic checked against a transaction-level model: each
    // granted request completes 2 (write) or 2+lat (read) cycles after it
    // is accepted, and the port is free again the cycle after completion.
    task automatic test_random(input bit sel, input int lat, input int ncyc);
        logic [15:0] m_mem [16];
        logic [15:0] m_rdata [2];
        bit          outstanding [2];
        bit          m_active = 0;
        int          m_who = 0, m_last = 1, m_start = 0, m_ack_cyc = 0, m_next_free = 0;
        logic        m_grant = 1'b0, m_we = 1'b0;
        logic [3:0]  m_addr = 4'd0;
        logic [15:0] m_wdata = 16'd0, m_val = 16'd0;
        logic        e_ack0, e_ack1, e_busy, e_we, rq;
        int          w;
        do_reset();
        sel_dut = sel;
        m_rdata[0] = '0; m_rdata[1] = '0;
        outstanding[0] = 0; outstanding[1] = 0;
        for (int a = 0; a < 16; a++) begin
            m_mem[a] = 16'($urandom);
            preload(4'(a), m_mem[a]);
        end
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            e_ack0 = 1'b0; e_ack1 = 1'b0;
            if (m_active && cyc == m_ack_cyc) begin
                if (!m_we) m_rdata[m_who] = m_val;
                if (m_who == 0) e_ack0 = 1'b1; else e_ack1 = 1'b1;
            end
            e_busy = m_active && cyc > m_start;
            e_we   = m_active && m_we && cyc == m_start + 1;
            n_total++;
            if ({v_r0_ack, v_r1_ack, v_busy, v_mem_we, v_grant} !== {e_ack0, e_ack1, e_busy, e_we, m_grant}) begin
                n_bad++;
                $display("FAIL rnd_ctrl lat%0d cyc%0d: got ack0,ack1,busy,we,grant=%b want %b", lat, cyc,
                         {v_r0_ack, v_r1_ack, v_busy, v_mem_we, v_grant}, {e_ack0, e_ack1, e_busy, e_we, m_grant});
            end
            n_total++;
            if ({v_r0_rdata, v_r1_rdata} !== {m_rdata[0], m_rdata[1]}) begin
                n_bad++;
                $display("FAIL rnd_rdata lat%0d cyc%0d: got %h %h want %h %h", lat, cyc,
                         v_r0_rdata, v_r1_rdata, m_rdata[0], m_rdata[1]);
            end
            if (e_busy) begin
                n_total++;
                if ({v_mem_addr, v_mem_in} !== {m_addr, m_wdata}) begin
                    n_bad++;
                    $display("FAIL rnd_mem lat%0d cyc%0d: got addr=%0d in=%h want %0d %h", lat, cyc,
                             v_mem_addr, v_mem_in, m_addr, m_wdata);
                end
            end
            if (m_active && cyc == m_ack_cyc) begin
                m_active = 0;
                outstanding[m_who] = 0;
                rq = (m_who == 0) ? r0_req : r1_req;
                if (rq) begin
                    if ($urandom_range(1, 0) == 1)
                        set_req(m_who, 1'b1, 1'($urandom), 4'($urandom), 16'($urandom));
                    else
                        set_req(m_who, 1'b0, 1'b0, 4'd0, 16'd0);
                end
            end
            for (int i = 0; i < 2; i++) begin
                rq = (i == 0) ? r0_req : r1_req;
                if (outstanding[i] && rq && $urandom_range(3, 0) == 0)
                    set_req(i, 1'b0, 1'b0, 4'd0, 16'd0);
                else if (!outstanding[i] && !rq && $urandom_range(1, 0) == 1)
                    set_req(i, 1'b1, 1'($urandom), 4'($urandom), 16'($urandom));
            end
            if (!m_active && cyc >= m_next_free && (r0_req || r1_req)) begin
                if (r0_req && r1_req) w = (m_last == 0) ? 1 : 0;
                else w = r1_req ? 1 : 0;
                m_we    = (w == 1) ? r1_we    : r0_we;
                m_addr  = (w == 1) ? r1_addr  : r0_addr;
                m_wdata = (w == 1) ? r1_wdata : r0_wdata;
                if (m_we) m_mem[m_addr] = m_wdata; else m_val = m_mem[m_addr];
                m_who = w; m_last = w; m_grant = logic'(w);
                m_start = cyc;
                m_ack_cyc = cyc + 2 + (m_we ? 0 : lat);
                m_next_free = m_ack_cyc + 1;
                outstanding[w] = 1;
                m_active = 1;
            end
            step();
        end
        set_req(0, 1'b0, 1'b0, 4'd0, 16'd0);
        set_req(1, 1'b0, 1'b0, 4'd0, 16'd0);
        sel_dut = 1'b0;
    endtask

    // Hard stop if something leaves the sequence stuck.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_dropped_req();
        test_reset_mid_read();
        test_latency1();
        test_random(1'b0, 2, 600);
        test_random(1'b1, 1, 600);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
